out_uart_tx: RTL and testbench

- Downstream consumer of the CPU output port.
- Each cycle the CPU asserts output_valid, this block captures the 16-bit out_port word into a small FIFO.
- It serialises each word as two 8N1 UART bytes on a single tx line: low byte first, then high byte.
- It decouples CPU OUT instruction timing from the slow serial link and reports dropped words.

---
 rtl/out_uart_tx.sv | 93 +++++++++
 tb/tb_out_uart_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/out_uart_tx.sv
// out_uart_tx: buffers CPU output words in a FIFO and sends each as two 8N1 UART bytes,
// low byte first, on an idle-high tx line.
module out_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        word_in,
  input  logic               word_valid,
  output logic               tx,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_count
);
  typedef enum logic [2:0] {IDLE, START_LO, DATA_LO, STOP_LO, START_HI, DATA_HI, STOP_HI} state_t;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(FIFO_DEPTH);
  state_t state;
  logic [15:0] mem [FIFO_DEPTH];
  logic [15:0] holding;
  logic [15:0] baud_cnt;
  logic [2:0] bit_idx;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic full, push, pop, baud_done;
  logic [7:0] cur_byte;
  assign full = fifo_count == DEPTH;
  assign push = word_valid && !full;
  assign pop = state == IDLE && fifo_count != '0;
  assign baud_done = baud_cnt == BAUD_LAST;
  assign cur_byte = (state == START_HI || state == DATA_HI) ? holding[15:8] : holding[7:0];
  assign busy = state != IDLE || fifo_count != '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= word_in;
  // fullness uses the pre-edge count, so a push at full is dropped even when a pop coincides
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (word_valid && full) overflow <= 1'b1;
      fifo_count <= (push && !pop) ? fifo_count + (FIFO_AW + 1)'(1) :
                    (pop && !push) ? fifo_count - (FIFO_AW + 1)'(1) : fifo_count;
    end
  // tx is loaded together with the state it belongs to, so it is valid for the whole state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tx <= 1'b1;
      holding <= '0;
      baud_cnt <= '0;
      bit_idx <= '0;
    end else if (state == IDLE) begin
      tx <= !pop;
      baud_cnt <= '0;
      if (pop) begin
        state <= START_LO;
        holding <= mem[rd_ptr];
      end
    end else if (!baud_done) begin
      baud_cnt <= baud_cnt + 16'd1;
    end else begin
      baud_cnt <= '0;
      case (state)
        START_LO, START_HI: begin
          state <= state == START_LO ? DATA_LO : DATA_HI;
          bit_idx <= '0;
          tx <= cur_byte[0];
        end
        DATA_LO, DATA_HI:
          if (bit_idx == 3'd7) begin
            state <= state == DATA_LO ? STOP_LO : STOP_HI;
            tx <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            tx <= cur_byte[bit_idx + 3'd1];
          end
        STOP_LO: begin
          state <= START_HI;
          tx <= 1'b0;
        end
        default: begin
          state <= IDLE;
          tx <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_out_uart_tx.sv
// tb_out_uart_tx: directed bench for out_uart_tx; a UART monitor checks received bytes
// against a queue filled when words are pushed.
module tb_out_uart_tx;
  localparam int C = 4;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic word_valid = 1'b0;
  logic [15:0] word_in = '0;
  logic tx, busy, overflow;
  logic [3:0] fifo_count;
  int passed = 0, total = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  bit m_on = 1'b0;
  int m_t = 0;
  logic [7:0] m_byte = '0;

  out_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .FIFO_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic fb(input logic [15:0] w, input int i);
    return i == 0 ? 1'b0 : i < 9 ? w[i-1] : i == 9 ? 1'b1 : i == 10 ? 1'b0 : i < 19 ? w[i-3] : 1'b1;
  endfunction

  task automatic push_word(input logic [15:0] w, input bit acc);
    word_in = w;
    word_valid = 1'b1;
    @(posedge clk);
    #1 word_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
  endtask

  task automatic wait_idle(input int lim);
    int i = 0;
    while (busy !== 1'b0 && i < lim) begin
      @(posedge clk);
      #1 i++;
    end
    chk("idle_wait", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
  endtask

  // receiver: start seen at m_t=0, each bit sampled mid-bit
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) m_on = 1'b0;
    else if (!m_on) begin
      if (tx === 1'b0) begin
        m_on = 1'b1;
        m_t = 0;
        m_byte = '0;
        starts.push_back(cyc);
      end
    end else begin
      m_t++;
      if (m_t < 9 * C && m_t % C == C / 2) m_byte[m_t / C - 1] = tx;
      if (m_t == 9 * C + C / 2) begin
        chk("stop_bit", tx, 1);
        e = exp_q.size() != 0 ? {1'b0, exp_q.pop_front()} : 9'h100;
        chk("rx_byte", {1'b0, m_byte}, e);
        m_on = 1'b0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_word(16'hA55A, 1);
    chk("t1_count", fifo_count, 1);
    chk("t1_tx_pre", tx, 1);
    for (int j = 0; j < 20 * C; j++) begin
      @(posedge clk);
      #1 chk("t1_wave", tx, fb(16'hA55A, j / C));
    end
    chk("t1_busy_80", busy, 1);
    @(posedge clk);
    #1;
    chk("t1_busy_81", busy, 0);
    chk("t1_tx_idle", tx, 1);
    wait_idle(20);
    starts.delete();
    push_word(16'h0001, 1);
    chk("t2_count1", fifo_count, 1);
    push_word(16'h0002, 1);
    chk("t2_count2", fifo_count, 1);
    push_word(16'h0003, 1);
    chk("t2_count3", fifo_count, 2);
    wait_idle(400);
    chk("t2_nbytes", starts.size(), 6);
    if (starts.size() == 6)
      for (int i = 1; i < 6; i++) chk("t2_gap", starts[i] - starts[i-1], i % 2 ? 10 * C : 10 * C + 1);
    chk("t3_ovf_pre", overflow, 0);
    for (int i = 0; i < 10; i++) push_word(16'h1100 + 16'(i), i < 9);
    chk("t3_ovf", overflow, 1);
    chk("t3_count", fifo_count, D);
    wait_idle(1000);
    chk("t3_ovf_sticky", overflow, 1);
    do_reset();
    chk("t4_ovf_cleared", overflow, 0);
    for (int i = 0; i < 9; i++) push_word(16'h2200 + 16'(i), 1);
    chk("t4_ovf_pre", overflow, 0);
    chk("t4_full", fifo_count, D);
    repeat (73) @(posedge clk);
    #1 push_word(16'hDEAD, 0);
    chk("t4_ovf", overflow, 1);
    chk("t4_count", fifo_count, D - 1);
    wait_idle(1000);
    push_word(16'hF0F0, 1);
    push_word(16'h1111, 1);
    push_word(16'h2222, 1);
    push_word(16'h3333, 1);
    repeat (52) @(posedge clk);
    #1;
    chk("t5_tx_pre", tx, 0);
    chk("t5_count_pre", fifo_count, 3);
    chk("t5_ovf_pre", overflow, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_tx", tx, 1);
    chk("t5_count", fifo_count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ovf", overflow, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 push_word(16'h1234, 1);
    wait_idle(200);
    for (int k = 0; k < 9; k++) begin
      push_word(16'h5000 + 16'(k), 1);
      chk("t6_count", fifo_count, k == 0 ? 1 : k);
      if (k < 8) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle(1200);
    chk("t6_ovf", overflow, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
